// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: decodes the IR fields, sequences the instruction
// phases, drives datapath/register-file controls and counts retired instructions.
module mc_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [4:0]       rs,
  input  logic             zero,
  output logic             pcwr,
  output logic             irwr,
  output logic             gprwr,
  output logic             dmwr,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemToReg,
  output logic             ALUSrc,
  output logic [1:0]       ExtOp,
  output logic [2:0]       ALUOp,
  output logic [1:0]       NPCOp,
  output logic             write_30,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_COP0  = 6'b010000;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;

  typedef enum logic [3:0] {
    S_FETCH = 4'd0,
    S_DCD   = 4'd1,
    S_MA    = 4'd2,
    S_MR    = 4'd3,
    S_MW    = 4'd4,
    S_WBM   = 4'd5,
    S_EXE   = 4'd6,
    S_WBA   = 4'd7,
    S_BR    = 4'd8,
    S_JMP   = 4'd9,
    S_WBC   = 4'd10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  logic i_addu, i_subu, i_slt, i_jr, i_ori, i_lui, i_addi, i_addiu;
  logic i_lw, i_sw, i_beq, i_j, i_jal, i_mfc0;
  logic is_rtype_alu, is_alu, is_mem, is_jump;

  logic [2:0] alu_op_c;
  logic [1:0] ext_op_c;
  logic       alu_src_c;

  // Instruction decode from the IR fields
  always_comb begin
    i_addu  = 1'b0; i_subu  = 1'b0; i_slt = 1'b0; i_jr  = 1'b0;
    i_ori   = 1'b0; i_lui   = 1'b0; i_addi = 1'b0; i_addiu = 1'b0;
    i_lw    = 1'b0; i_sw    = 1'b0; i_beq = 1'b0; i_j   = 1'b0;
    i_jal   = 1'b0; i_mfc0  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: i_addu = 1'b1;
          FN_SUBU: i_subu = 1'b1;
          FN_SLT:  i_slt  = 1'b1;
          FN_JR:   i_jr   = 1'b1;
          default: ;
        endcase
      end
      OP_ORI:   i_ori   = 1'b1;
      OP_LUI:   i_lui   = 1'b1;
      OP_ADDI:  i_addi  = 1'b1;
      OP_ADDIU: i_addiu = 1'b1;
      OP_LW:    i_lw    = 1'b1;
      OP_SW:    i_sw    = 1'b1;
      OP_BEQ:   i_beq   = 1'b1;
      OP_J:     i_j     = 1'b1;
      OP_JAL:   i_jal   = 1'b1;
      OP_COP0:  i_mfc0  = (rs == 5'd0);
      default: ;
    endcase
  end

  assign is_rtype_alu = i_addu | i_subu | i_slt;
  assign is_alu       = is_rtype_alu | i_ori | i_lui | i_addi | i_addiu;
  assign is_mem       = i_lw | i_sw;
  assign is_jump      = i_j | i_jal | i_jr;

  // ALU controls shared by EXE and WBA so the result stays stable into writeback
  always_comb begin
    alu_op_c  = ALU_ADD;
    ext_op_c  = 2'b00;
    alu_src_c = 1'b0;
    if (i_subu) alu_op_c = ALU_SUB;
    if (i_slt)  alu_op_c = ALU_SLT;
    if (i_ori || i_lui) alu_op_c = ALU_OR;
    if (i_ori || i_lui || i_addi || i_addiu) alu_src_c = 1'b1;
    if (i_lui) ext_op_c = 2'b10;
    if (i_addi || i_addiu) ext_op_c = 2'b01;
  end

  // Next state and Moore outputs; reset masks every output to its idle value
  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    pcwr     = 1'b0;
    irwr     = 1'b0;
    gprwr    = 1'b0;
    dmwr     = 1'b0;
    RegDst   = 2'b00;
    MemToReg = 2'b00;
    ALUSrc   = 1'b0;
    ExtOp    = 2'b00;
    ALUOp    = ALU_ADD;
    NPCOp    = 2'b00;
    write_30 = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwr    = 1'b1;
        pcwr    = 1'b1;
        state_d = S_DCD;
      end
      S_DCD: begin
        if (is_mem)       state_d = S_MA;
        else if (is_alu)  state_d = S_EXE;
        else if (i_beq)   state_d = S_BR;
        else if (is_jump) state_d = S_JMP;
        else if (i_mfc0)  state_d = S_WBC;
        else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MA: begin
        ALUSrc  = 1'b1;
        ExtOp   = 2'b01;
        ALUOp   = ALU_ADD;
        state_d = i_lw ? S_MR : S_MW;
      end
      S_MR: state_d = S_WBM;
      S_MW: begin
        dmwr    = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_WBM: begin
        gprwr    = 1'b1;
        MemToReg = 2'b01;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXE: begin
        ALUOp   = alu_op_c;
        ALUSrc  = alu_src_c;
        ExtOp   = ext_op_c;
        state_d = S_WBA;
      end
      S_WBA: begin
        ALUOp    = alu_op_c;
        ALUSrc   = alu_src_c;
        ExtOp    = ext_op_c;
        gprwr    = 1'b1;
        RegDst   = is_rtype_alu ? 2'b01 : 2'b00;
        write_30 = i_addi;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BR: begin
        ALUOp   = ALU_SUB;
        NPCOp   = 2'b01;
        pcwr    = zero;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JMP: begin
        pcwr  = 1'b1;
        NPCOp = i_jr ? 2'b11 : 2'b10;
        if (i_jal) begin
          gprwr    = 1'b1;
          RegDst   = 2'b10;
          MemToReg = 2'b10;
        end
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_WBC: begin
        gprwr    = 1'b1;
        MemToReg = 2'b11;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (rst) begin
      pcwr     = 1'b0;
      irwr     = 1'b0;
      gprwr    = 1'b0;
      dmwr     = 1'b0;
      RegDst   = 2'b00;
      MemToReg = 2'b00;
      ALUSrc   = 1'b0;
      ExtOp    = 2'b00;
      ALUOp    = ALU_ADD;
      NPCOp    = 2'b00;
      write_30 = 1'b0;
      illegal  = 1'b0;
    end
  end

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule
